// File: rtl/game_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : game_pkg                                                      |
// | Purpose  : Shared display geometry, coordinate widths and slot record    |
// |            types for the VGA shooter object pools.                       |
// | Ports    : none (package)                                                |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
package game_pkg;

   localparam int DISP_H   = 640;
   localparam int DISP_V   = 480;
   localparam int BULLET_W = 6;
   localparam int BULLET_H = 20;
   localparam int X_W      = 10;
   localparam int Y_W      = 9;
   localparam int VEL_W    = 4;

   typedef struct packed {
      logic [X_W-1:0] x;
      logic [Y_W-1:0] y;
   } pos_t;

   typedef struct packed {
      logic                    active;
      logic [X_W-1:0]          x;
      logic [Y_W-1:0]          y;
      logic signed [VEL_W-1:0] dx;
      logic signed [VEL_W-1:0] dy;
   } slot_t;

endpackage
`default_nettype wire

// File: rtl/bullet_slot_alloc.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : bullet_slot_alloc                                             |
// | Purpose  : Combinational lowest-free-slot priority encoder.              |
// | Ports    : i_Active - per-slot active flags                              |
// |            o_Found  - at least one slot is free                          |
// |            o_Idx    - index of the lowest free slot (0 when none)        |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module bullet_slot_alloc
   import game_pkg::*;
#(
   parameter int N_SLOT = 16,
   parameter int IDX_W  = $clog2(N_SLOT)
) (
   input  logic [N_SLOT-1:0] i_Active,
   output logic              o_Found,
   output logic [IDX_W-1:0]  o_Idx
);

   // Scan from the top down so the last hit, the lowest index, wins.
   always_comb begin
      o_Found = 1'b0;
      o_Idx   = '0;
      for (int k = N_SLOT - 1; k >= 0; k--) begin
         if (!i_Active[k]) begin
            o_Found = 1'b1;
            o_Idx   = IDX_W'(k);
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/bullet_pool_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : bullet_pool_engine                                            |
// | Purpose  : N-slot bullet pool: fire into lowest free slot, per-tick      |
// |            signed movement, off-screen retire, collision kill, and a     |
// |            combinational read port for the renderer.                     |
// | Ports    : i_Clk/i_Rst (async, active-low), i_Tick frame strobe,         |
// |            i_Fire + spawn X/Y/Dx/Dy, i_KillMask, i_RdIdx;                |
// |            o_FireAck/o_FireDrop/o_FireSlot, o_Active, o_Count,           |
// |            o_RdX/o_RdY/o_RdActive                                        |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module bullet_pool_engine
   import game_pkg::*;
#(
   parameter int N_SLOT   = 16,
   parameter int X_W      = game_pkg::X_W,
   parameter int Y_W      = game_pkg::Y_W,
   parameter int VEL_W    = game_pkg::VEL_W,
   parameter int DISP_H   = game_pkg::DISP_H,
   parameter int DISP_V   = game_pkg::DISP_V,
   parameter int BULLET_W = game_pkg::BULLET_W,
   parameter int BULLET_H = game_pkg::BULLET_H,
   parameter int COOLDOWN = 11
) (
   input  logic                         i_Clk,
   input  logic                         i_Rst,
   input  logic                         i_Tick,
   input  logic                         i_Fire,
   input  logic [X_W-1:0]               i_FireX,
   input  logic [Y_W-1:0]               i_FireY,
   input  logic [VEL_W-1:0]             i_FireDx,
   input  logic [VEL_W-1:0]             i_FireDy,
   input  logic [N_SLOT-1:0]            i_KillMask,
   input  logic [$clog2(N_SLOT)-1:0]    i_RdIdx,
   output logic                         o_FireAck,
   output logic                         o_FireDrop,
   output logic [$clog2(N_SLOT)-1:0]    o_FireSlot,
   output logic [N_SLOT-1:0]            o_Active,
   output logic [X_W-1:0]               o_RdX,
   output logic [Y_W-1:0]               o_RdY,
   output logic                         o_RdActive,
   output logic [$clog2(N_SLOT+1)-1:0]  o_Count
);

   localparam int IDX_W = $clog2(N_SLOT);
   localparam int CNT_W = $clog2(N_SLOT + 1);
   localparam int CD_W  = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

   // Highest legal top-left corner that keeps the whole sprite on screen.
   localparam logic signed [X_W:0] X_LIM = (X_W+1)'(DISP_H - BULLET_W);
   localparam logic signed [Y_W:0] Y_LIM = (Y_W+1)'(DISP_V - BULLET_H);

   logic [N_SLOT-1:0] act_q, act_d;
   logic [X_W-1:0]    x_q  [N_SLOT];
   logic [X_W-1:0]    x_d  [N_SLOT];
   logic [Y_W-1:0]    y_q  [N_SLOT];
   logic [Y_W-1:0]    y_d  [N_SLOT];
   logic [VEL_W-1:0]  dx_q [N_SLOT];
   logic [VEL_W-1:0]  dx_d [N_SLOT];
   logic [VEL_W-1:0]  dy_q [N_SLOT];
   logic [VEL_W-1:0]  dy_d [N_SLOT];
   logic [CD_W-1:0]   cool_q, cool_d;
   logic              ack_q, drop_q;
   logic [IDX_W-1:0]  slot_q, slot_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic              w_found;
   logic [IDX_W-1:0]  w_idx;
   logic              w_accept;

   // Positions are unsigned on screen; widen by one bit so a step past
   // either edge shows up as negative or above the limit.
   function automatic logic signed [X_W:0] add_x(input logic [X_W-1:0] p,
                                                 input logic [VEL_W-1:0] v);
      return $signed({1'b0, p}) + $signed({{(X_W+1-VEL_W){v[VEL_W-1]}}, v});
   endfunction

   function automatic logic signed [Y_W:0] add_y(input logic [Y_W-1:0] p,
                                                 input logic [VEL_W-1:0] v);
      return $signed({1'b0, p}) + $signed({{(Y_W+1-VEL_W){v[VEL_W-1]}}, v});
   endfunction

   bullet_slot_alloc #(
      .N_SLOT (N_SLOT),
      .IDX_W  (IDX_W)
   ) u_alloc (
      .i_Active (act_q),
      .o_Found  (w_found),
      .o_Idx    (w_idx)
   );

   assign w_accept = i_Fire && (cool_q == '0) && w_found;

   always_comb begin
      act_d  = act_q;
      x_d    = x_q;
      y_d    = y_q;
      dx_d   = dx_q;
      dy_d   = dy_q;
      slot_d = w_accept ? w_idx : slot_q;
      for (int k = 0; k < N_SLOT; k++) begin
         // The allocated slot is inactive in the current state, so the
         // load never competes with a kill or a move on the same slot.
         if (w_accept && (w_idx == IDX_W'(k))) begin
            act_d[k] = 1'b1;
            x_d[k]   = i_FireX;
            y_d[k]   = i_FireY;
            dx_d[k]  = i_FireDx;
            dy_d[k]  = i_FireDy;
         end else if (act_q[k] && i_KillMask[k]) begin
            act_d[k] = 1'b0;
         end else if (act_q[k] && i_Tick) begin
            if (add_x(x_q[k], dx_q[k]) < 0 || add_x(x_q[k], dx_q[k]) > X_LIM ||
                add_y(y_q[k], dy_q[k]) < 0 || add_y(y_q[k], dy_q[k]) > Y_LIM) begin
               act_d[k] = 1'b0;
            end else begin
               x_d[k] = X_W'(add_x(x_q[k], dx_q[k]));
               y_d[k] = Y_W'(add_y(y_q[k], dy_q[k]));
            end
         end
      end
   end

   always_comb begin
      cnt_d = '0;
      for (int k = 0; k < N_SLOT; k++) begin
         cnt_d = cnt_d + CNT_W'(act_d[k]);
      end
   end

   // A fresh load wins over the tick decrement in the same cycle.
   always_comb begin
      cool_d = cool_q;
      if (w_accept) begin
         cool_d = CD_W'(COOLDOWN);
      end else if (i_Tick && (cool_q != '0)) begin
         cool_d = cool_q - 1'b1;
      end
   end

   always_ff @(posedge i_Clk or negedge i_Rst) begin
      if (!i_Rst) begin
         act_q  <= '0;
         x_q    <= '{default: '0};
         y_q    <= '{default: '0};
         dx_q   <= '{default: '0};
         dy_q   <= '{default: '0};
         cool_q <= '0;
         ack_q  <= 1'b0;
         drop_q <= 1'b0;
         slot_q <= '0;
         cnt_q  <= '0;
      end else begin
         act_q  <= act_d;
         x_q    <= x_d;
         y_q    <= y_d;
         dx_q   <= dx_d;
         dy_q   <= dy_d;
         cool_q <= cool_d;
         ack_q  <= w_accept;
         drop_q <= i_Fire && !w_accept;
         slot_q <= slot_d;
         cnt_q  <= cnt_d;
      end
   end

   assign o_FireAck  = ack_q;
   assign o_FireDrop = drop_q;
   assign o_FireSlot = slot_q;
   assign o_Active   = act_q;
   assign o_Count    = cnt_q;

   always_comb begin
      o_RdX      = '0;
      o_RdY      = '0;
      o_RdActive = 1'b0;
      if (int'(i_RdIdx) < N_SLOT) begin
         o_RdX      = x_q[i_RdIdx];
         o_RdY      = y_q[i_RdIdx];
         o_RdActive = act_q[i_RdIdx];
      end
   end

endmodule
`default_nettype wire
